// File: rtl/matrix_mem_arbiter.sv
// matrix_mem_arbiter
// Shares one single-port synchronous matrix RAM between the multiply
// sequencer (port 0) and the load/view controller (port 1). Requests are
// serialised through a small IDLE -> ISSUE -> (WAIT_RD) -> IDLE machine.
// Ties are resolved round-robin unless MEM_ARB_FIXED_PRIO_EN is defined, in
// which case port 0 always wins ties and port 1 may starve.
module matrix_mem_arbiter #(
  parameter int AW     = 5,
  parameter int DW     = 16,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT_RD = 2'd2;

  // The wait counter is two bits wide, which bounds the supported latency.
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
    $error("matrix_mem_arbiter: RD_LAT must be in 1..3");
  end

  logic [1:0]    state;
  logic [1:0]    cnt;
  logic          pick;
  logic          winner;
  logic          sel_id;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          in_issue;

`ifndef MEM_ARB_FIXED_PRIO_EN
  // Port served by the most recent selection; the other port wins a tie.
  logic          last_port;
`endif

  // Choose which requester would be selected this cycle if the arbiter is idle.
  always_comb begin
    pick = r0_req | r1_req;
`ifdef MEM_ARB_FIXED_PRIO_EN
    winner = ~r0_req;
`else
    if (r0_req && r1_req) begin
      winner = ~last_port;
    end else begin
      winner = ~r0_req;
    end
`endif
  end

  // Main sequencer: selection, one-cycle issue and the read-latency wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      sel_id    <= 1'b0;
      sel_we    <= 1'b0;
      sel_addr  <= '0;
      sel_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick) begin
            sel_id    <= winner;
            sel_we    <= winner ? r1_we    : r0_we;
            sel_addr  <= winner ? r1_addr  : r0_addr;
            sel_wdata <= winner ? r1_wdata : r0_wdata;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (sel_we) begin
            state <= IDLE;
          end else begin
            cnt   <= 2'(RD_LAT);
            state <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef MEM_ARB_FIXED_PRIO_EN
  // Round-robin pointer: remember who was picked so the other port wins next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_port <= 1'b1;
    end else if (state == IDLE && pick) begin
      last_port <= winner;
    end
  end
`endif

  // Read return: capture RAM data on the last wait cycle and pulse the owner's rvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata     <= '0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
    end else begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      if (state == WAIT_RD && cnt == 2'd1) begin
        rdata     <= mem_rdata;
        r0_rvalid <= ~sel_id;
        r1_rvalid <= sel_id;
      end
    end
  end

  // The RAM sees the latched transaction; the address holds through the read wait.
  assign in_issue  = (state == ISSUE);
  assign mem_addr  = sel_addr;
  assign mem_wdata = sel_wdata;
  assign mem_we    = in_issue & sel_we;
  assign r0_gnt    = in_issue & ~sel_id;
  assign r1_gnt    = in_issue & sel_id;
  assign busy      = (state != IDLE);

endmodule
